// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the stack CPU: state enum, opcodes and the
// datapath select encodings used by the controller and the PC/SP/memory block.
package ctrl_defs;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_ALU, S_WB, S_MADDR, S_MRD,
        S_MWR, S_SPDEC, S_PUSHWR, S_BR, S_JMP, S_HALT, S_TRAP
    } state_t;

    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h6;
    localparam logic [3:0] OP_POP  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_J    = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] MDST_PC    = 3'd0;
    localparam logic [2:0] MDST_ZE    = 3'd1;
    localparam logic [2:0] MDST_LS    = 3'd2;
    localparam logic [2:0] MDST_SP    = 3'd3;
    localparam logic [2:0] MDST_SP2   = 3'd4;
    localparam logic [2:0] MDST_MARY  = 3'd5;

    localparam logic [1:0] MSRC_MARY    = 2'd0;
    localparam logic [1:0] MSRC_SHELLEY = 2'd1;
    localparam logic [1:0] MSRC_RA      = 2'd2;
    localparam logic [1:0] MSRC_COMP    = 2'd3;

    localparam logic [2:0] PCS_PC2    = 3'd0;
    localparam logic [2:0] PCS_IMM    = 3'd1;
    localparam logic [2:0] PCS_MARY   = 3'd2;
    localparam logic [2:0] PCS_JCMP   = 3'd3;
    localparam logic [2:0] PCS_RA     = 3'd4;

    localparam logic [2:0] SPS_HOLD = 3'd0;
    localparam logic [2:0] SPS_INC  = 3'd1;
    localparam logic [2:0] SPS_DEC  = 3'd2;
    localparam logic [2:0] SPS_MARY = 3'd3;

    typedef struct packed {
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       mem_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [2:0] sp_src;
        logic       jcmp;
        logic       pc_reset;
        logic       sp_reset;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       halted;
        logic       trap;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> PC/SP/memory block bundle: instruction/compare feedback in,
// control word out. master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;
    logic        enable;
    logic [15:0] inst;
    logic        cmp_eq;
    logic        PCWrite;
    logic        SPWrite;
    logic        InstWrite;
    logic        MemWrite;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst;
    logic [2:0]  PCSrc;
    logic [2:0]  SPSrc;
    logic        jcmp;
    logic        PCReset;
    logic        SPReset;
    logic        RegWrite;
    logic [1:0]  ALUOp;
    logic        halted;
    logic        trap;

    modport master (
        input  enable, inst, cmp_eq,
        output PCWrite, SPWrite, InstWrite, MemWrite, MemSrc, MemDst, PCSrc,
               SPSrc, jcmp, PCReset, SPReset, RegWrite, ALUOp, halted, trap
    );

    modport slave (
        output enable, inst, cmp_eq,
        input  PCWrite, SPWrite, InstWrite, MemWrite, MemSrc, MemDst, PCSrc,
               SPSrc, jcmp, PCReset, SPReset, RegWrite, ALUOp, halted, trap
    );
endinterface

// File: rtl/multicycle_control_fsm_output_decode.sv
// Moore control-word decode from the controller state and latched opcode.
// S_TRAP decodes trap only when CTRL_ILLEGAL_TRAP_EN is defined.
module ctrl_output_decode
    import ctrl_defs::*;
#(
    parameter int OPC_W = 4
) (
    input  state_t           state,
    input  logic [OPC_W-1:0] opc,
    input  logic             cmp_eq,
    output ctrl_word_t       cw
);

    logic is_pop;
    assign is_pop = (opc == OPC_W'(OP_POP));

    always_comb begin
        cw = '0;
        case (state)
            S_RESET: begin
                cw.pc_reset = 1'b1;
                cw.sp_reset = 1'b1;
                cw.pc_write = 1'b1;
                cw.sp_write = 1'b1;
            end
            S_FETCH: begin
                cw.mem_dst    = MDST_PC;
                cw.inst_write = 1'b1;
            end
            S_DECODE: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PCS_PC2;
            end
            S_ALU:   cw.alu_op    = opc[1:0];
            S_WB:    cw.reg_write = 1'b1;
            S_MADDR: cw.mem_dst   = is_pop ? MDST_SP : MDST_ZE;
            S_MRD: begin
                cw.mem_dst = is_pop ? MDST_SP : MDST_ZE;
                // POP post-increments SP while the top-of-stack read is on the bus
                if (is_pop) begin
                    cw.sp_write = 1'b1;
                    cw.sp_src   = SPS_INC;
                end
            end
            S_MWR: begin
                cw.mem_write = 1'b1;
                cw.mem_src   = MSRC_SHELLEY;
                cw.mem_dst   = MDST_ZE;
            end
            S_SPDEC: begin
                cw.sp_write = 1'b1;
                cw.sp_src   = SPS_DEC;
            end
            S_PUSHWR: begin
                cw.mem_write = 1'b1;
                cw.mem_src   = MSRC_SHELLEY;
                cw.mem_dst   = MDST_SP;
            end
            S_BR: begin
                cw.jcmp     = 1'b1;
                cw.pc_src   = PCS_JCMP;
                cw.pc_write = cmp_eq;
            end
            S_JMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = (opc == OPC_W'(OP_J)) ? PCS_IMM : PCS_MARY;
            end
            S_HALT: cw.halted = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: cw.trap = 1'b1;
`endif
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller for the 16-bit stack CPU; one state per clock.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal opcode -> sticky S_TRAP).
module multicycle_control_fsm
    import ctrl_defs::*;
#(
    parameter int OPC_W        = 4,
    parameter int RESET_CYCLES = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    state_t           state, state_nxt;
    logic [OPC_W-1:0] opc, opc_nxt;
    logic [3:0]       rst_cnt, rst_cnt_nxt;
    logic [OPC_W-1:0] op_in;
    ctrl_word_t       cw;

    assign op_in = bus.inst[15 -: OPC_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_RESET;
            rst_cnt <= '0;
            opc     <= '0;
        end else if (bus.enable) begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
            opc     <= opc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        opc_nxt     = opc;
        case (state)
            S_RESET: begin
                if (rst_cnt == 4'(RESET_CYCLES - 1)) begin
                    state_nxt   = S_FETCH;
                    rst_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 4'd1;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                opc_nxt = op_in;
                if (op_in < OPC_W'(4)) begin
                    state_nxt = S_ALU;
                end else begin
                    case (op_in)
                        OPC_W'(OP_LW):   state_nxt = S_MADDR;
                        OPC_W'(OP_SW):   state_nxt = S_MWR;
                        OPC_W'(OP_PUSH): state_nxt = S_SPDEC;
                        OPC_W'(OP_POP):  state_nxt = S_MADDR;
                        OPC_W'(OP_BEQ):  state_nxt = S_BR;
                        OPC_W'(OP_J):    state_nxt = S_JMP;
                        OPC_W'(OP_JR):   state_nxt = S_JMP;
                        OPC_W'(OP_HALT): state_nxt = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:         state_nxt = S_TRAP;
`else
                        default:         state_nxt = S_FETCH;
`endif
                    endcase
                end
            end
            S_ALU:    state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_MADDR:  state_nxt = S_MRD;
            S_MRD:    state_nxt = S_WB;
            S_MWR:    state_nxt = S_FETCH;
            S_SPDEC:  state_nxt = S_PUSHWR;
            S_PUSHWR: state_nxt = S_FETCH;
            S_BR:     state_nxt = S_FETCH;
            S_JMP:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_RESET;
        endcase
    end

    ctrl_output_decode #(.OPC_W(OPC_W)) u_decode (
        .state  (state),
        .opc    (opc),
        .cmp_eq (bus.cmp_eq),
        .cw     (cw)
    );

    // Freezing gates only the write strobes; selects stay decoded for the datapath
    assign bus.PCWrite   = cw.pc_write   & bus.enable;
    assign bus.SPWrite   = cw.sp_write   & bus.enable;
    assign bus.InstWrite = cw.inst_write & bus.enable;
    assign bus.MemWrite  = cw.mem_write  & bus.enable;
    assign bus.RegWrite  = cw.reg_write  & bus.enable;
    assign bus.MemSrc    = cw.mem_src;
    assign bus.MemDst    = cw.mem_dst;
    assign bus.PCSrc     = cw.pc_src;
    assign bus.SPSrc     = cw.sp_src;
    assign bus.jcmp      = cw.jcmp;
    assign bus.PCReset   = cw.pc_reset;
    assign bus.SPReset   = cw.sp_reset;
    assign bus.ALUOp     = cw.alu_op;
    assign bus.halted    = cw.halted;
    assign bus.trap      = cw.trap;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares the full control word against hand-built values.
module tb_multicycle_control_fsm;

    logic clock = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.OPC_W(4), .RESET_CYCLES(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pcw, spw, iw, mw;
        logic [1:0] msrc;
        logic [2:0] mdst, pcsrc, spsrc;
        logic       jc, pcr, spr, rw;
        logic [1:0] alu;
        logic       hlt, trp;
    } cw_t;

    function automatic cw_t observed();
        cw_t o;
        o = {bus.PCWrite, bus.SPWrite, bus.InstWrite, bus.MemWrite, bus.MemSrc,
             bus.MemDst, bus.PCSrc, bus.SPSrc, bus.jcmp, bus.PCReset,
             bus.SPReset, bus.RegWrite, bus.ALUOp, bus.halted, bus.trap};
        return o;
    endfunction

    function automatic cw_t w_rst();
        cw_t e = '0;
        e.pcw = 1'b1; e.spw = 1'b1; e.pcr = 1'b1; e.spr = 1'b1;
        return e;
    endfunction

    function automatic cw_t w_fetch();
        cw_t e = '0;
        e.iw = 1'b1;
        return e;
    endfunction

    function automatic cw_t w_dec();
        cw_t e = '0;
        e.pcw = 1'b1;
        return e;
    endfunction

    function automatic cw_t w_wb();
        cw_t e = '0;
        e.rw = 1'b1;
        return e;
    endfunction

    function automatic cw_t w_mdst(input logic [2:0] d);
        cw_t e = '0;
        e.mdst = d;
        return e;
    endfunction

    task automatic chk(input string tag, input cw_t exp);
        cw_t obs;
        obs = observed();
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input cw_t exp);
        @(negedge clock);
        #1;
        chk(tag, exp);
    endtask

    cw_t e;

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.inst   = 16'h0000;
        bus.cmp_eq = 1'b0;

        // reset held for three edges, then one more RESET cycle after release
        step("rst0", w_rst());
        step("rst1", w_rst());
        step("rst2", w_rst());
        reset = 1'b0;
        #1 chk("rst_after", w_rst());

        // LW: FETCH DECODE MADDR MRD WB
        bus.inst = 16'h4003;
        step("lw_fetch", w_fetch());
        step("lw_dec",   w_dec());
        step("lw_maddr", w_mdst(3'd1));
        step("lw_mrd",   w_mdst(3'd1));
        step("lw_wb",    w_wb());

        // PUSH: SP decrement precedes the write at SP
        bus.inst = 16'h6000;
        step("push_fetch", w_fetch());
        step("push_dec",   w_dec());
        e = '0; e.spw = 1'b1; e.spsrc = 3'd2;
        step("push_spdec", e);
        e = '0; e.mw = 1'b1; e.msrc = 2'd1; e.mdst = 3'd3;
        step("push_wr", e);

        // POP
        bus.inst = 16'h7000;
        step("pop_fetch", w_fetch());
        step("pop_dec",   w_dec());
        step("pop_maddr", w_mdst(3'd3));
        e = '0; e.mdst = 3'd3; e.spw = 1'b1; e.spsrc = 3'd1;
        step("pop_mrd", e);
        step("pop_wb", w_wb());

        // BEQ not taken, then taken
        bus.inst = 16'h9005;
        bus.cmp_eq = 1'b0;
        step("beq0_fetch", w_fetch());
        step("beq0_dec",   w_dec());
        e = '0; e.jc = 1'b1; e.pcsrc = 3'd3;
        step("beq0_br", e);
        bus.cmp_eq = 1'b1;
        step("beq1_fetch", w_fetch());
        step("beq1_dec",   w_dec());
        e = '0; e.jc = 1'b1; e.pcsrc = 3'd3; e.pcw = 1'b1;
        step("beq1_br", e);
        bus.cmp_eq = 1'b0;

        // J then JR
        bus.inst = 16'hA123;
        step("j_fetch", w_fetch());
        step("j_dec",   w_dec());
        e = '0; e.pcw = 1'b1; e.pcsrc = 3'd1;
        step("j_jmp", e);
        bus.inst = 16'hB000;
        step("jr_fetch", w_fetch());
        step("jr_dec",   w_dec());
        e = '0; e.pcw = 1'b1; e.pcsrc = 3'd2;
        step("jr_jmp", e);

        // ALU AND then SUB
        bus.inst = 16'h2000;
        step("and_fetch", w_fetch());
        step("and_dec",   w_dec());
        e = '0; e.alu = 2'd2;
        step("and_alu", e);
        step("and_wb", w_wb());
        bus.inst = 16'h1000;
        step("sub_fetch", w_fetch());
        step("sub_dec",   w_dec());
        e = '0; e.alu = 2'd1;
        step("sub_alu", e);
        step("sub_wb", w_wb());

        // SW, with a freeze in FETCH that masks InstWrite
        bus.inst = 16'h5000;
        step("sw_fetch", w_fetch());
        bus.enable = 1'b0;
        #1 chk("sw_fetch_frz", '0);
        step("sw_fetch_frz2", '0);
        bus.enable = 1'b1;
        #1 chk("sw_fetch_resume", w_fetch());
        step("sw_dec", w_dec());
        e = '0; e.mw = 1'b1; e.msrc = 2'd1; e.mdst = 3'd1;
        step("sw_mwr", e);

        // LW frozen for four cycles in MRD; RegWrite fires once on resume
        bus.inst = 16'h4000;
        step("lwf_fetch", w_fetch());
        step("lwf_dec",   w_dec());
        step("lwf_maddr", w_mdst(3'd1));
        step("lwf_mrd",   w_mdst(3'd1));
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) step("lwf_frozen", w_mdst(3'd1));
        bus.enable = 1'b1;
        step("lwf_wb", w_wb());
        step("lwf_next_fetch", w_fetch());

        // illegal opcode
        bus.inst = 16'hC000;
        step("ill_dec", w_dec());
`ifdef CTRL_ILLEGAL_TRAP_EN
        e = '0; e.trp = 1'b1;
        step("ill_trap0", e);
        step("ill_trap1", e);
        step("ill_trap2", e);
`else
        step("ill_fetch", w_fetch());
        step("ill_dec2",  w_dec());
        step("ill_fetch2", w_fetch());
`endif
        reset = 1'b1;
        step("rst_mid", w_rst());
        reset = 1'b0;
        step("rst_mid_fetch", w_fetch());

        // HALT is sticky, even while frozen, until reset
        bus.inst = 16'hF000;
        step("halt_dec", w_dec());
        e = '0; e.hlt = 1'b1;
        step("halt0", e);
        step("halt1", e);
        bus.enable = 1'b0;
        step("halt_frz", e);
        bus.enable = 1'b1;
        step("halt2", e);
        reset = 1'b1;
        step("halt_rst", w_rst());
        reset = 1'b0;
        step("halt_rst_fetch", w_fetch());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle main controller for the 16-bit stack-oriented CPU.
- Sits directly upstream of the PC/SP/memory block and drives all of its control inputs: PCWrite, SPWrite, InstWrite, MemWrite, MemSrc, MemDst, PCSrc, SPSrc, jcmp, PCReset, SPReset.
- Consumes that block's Inst_out plus the comparator result.
- Sequences fetch, decode, execute, memory and writeback one state per clock.

Parameters:
- OPC_W, 4, opcode field width, taken from inst[15:12].
- RESET_CYCLES, 1, cycles spent in S_RESET asserting PCReset/SPReset before the first fetch (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; forces S_RESET.
- enable  in  1  0 = freeze state; all write strobes forced 0.
- inst  in  16  instruction register contents (Inst_out).
- cmp_eq  in  1  comparator result for BEQ.
- PCWrite  out  1  PC load enable.
- SPWrite  out  1  SP load enable.
- InstWrite  out  1  instruction register load.
- MemWrite  out  1  memory write strobe.
- MemSrc  out  2  memory write-data select.
- MemDst  out  3  memory address select.
- PCSrc  out  3  next-PC select.
- SPSrc  out  3  next-SP select.
- jcmp  out  1  selects the jcmpImm path.
- PCReset  out  1  clear PC.
- SPReset  out  1  clear SP.
- RegWrite  out  1  register file write.
- ALUOp  out  2  0 ADD, 1 SUB, 2 AND, 3 OR.
- halted  out  1  HALT executed.
- trap  out  1  illegal opcode (feature only).

Behaviour:
- All outputs are Moore decodes of the state register and the latched opcode register `opc`. Every output is 0 unless listed for the current state.
- Reset, including mid-instruction: next edge gives state = S_RESET, a reset-cycle counter cleared to 0, opc = 0.
  - S_RESET outputs: PCReset = SPReset = PCWrite = SPWrite = 1.
  - S_RESET stays RESET_CYCLES cycles, then goes to S_FETCH.
- Encodings:
  - MemDst: 0 PC, 1 ze_imm, 2 ls_imm, 3 SP, 4 SP+2, 5 Mary.
  - MemSrc: 0 Mary, 1 Shelley, 2 RA, 3 Comp.
  - PCSrc: 0 PC+2, 1 immPlusPC, 2 pcPlusMary, 3 jcmpImm, 4 RAData.
  - SPSrc: 0 hold, 1 SP+2, 2 SP-2, 3 Mary.
- S_FETCH: MemDst = 0, InstWrite = 1. Next state S_DECODE.
- S_DECODE: PCWrite = 1, PCSrc = 0; opc <= inst[15:12]. Next state by opcode:
  - 0x0-0x3 ALU -> S_ALU
  - 0x4 LW -> S_MADDR
  - 0x5 SW -> S_MWR
  - 0x6 PUSH -> S_SPDEC
  - 0x7 POP -> S_MADDR
  - 0x9 BEQ -> S_BR
  - 0xA J -> S_JMP
  - 0xB JR -> S_JMP
  - 0xF HALT -> S_HALT
  - others: illegal, see Optional Feature.
- S_ALU: ALUOp = opc[1:0] -> S_WB.
- S_WB: RegWrite = 1 -> S_FETCH.
- S_MADDR: MemDst = 1 for LW, 3 for POP -> S_MRD.
- S_MRD: same MemDst held. POP additionally asserts SPWrite = 1, SPSrc = 1. Next S_WB.
- S_MWR: MemWrite = 1, MemSrc = 1, MemDst = 1 -> S_FETCH.
- S_SPDEC: SPWrite = 1, SPSrc = 2 -> S_PUSHWR.
- S_PUSHWR: MemWrite = 1, MemSrc = 1, MemDst = 3 -> S_FETCH.
- S_BR: jcmp = 1, PCSrc = 3, PCWrite = cmp_eq -> S_FETCH.
- S_JMP: PCWrite = 1, PCSrc = 1 for J, 2 for JR -> S_FETCH.
- S_HALT: halted = 1. Sticky until reset.
- Latencies (cycles):
  - ALU 4, LW 5, POP 5, SW 3, PUSH 4, BEQ 3, J/JR 3.
  - HALT reaches S_HALT after 2.
- enable = 0: state, opc and counter hold; PCWrite, SPWrite, InstWrite, MemWrite and RegWrite forced 0; select outputs still decoded. Reset overrides enable.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in S_DECODE goes to S_TRAP. S_TRAP sets trap = 1 and holds all strobes 0 until reset.
- Undefined: an illegal opcode is a NOP (S_DECODE -> S_FETCH); trap is tied to 0.

Decomposition:
- Shared package `ctrl_defs`: state enum, opcode constants, and the MemSrc/MemDst/PCSrc/SPSrc encodings. Shared with the PC/SP/memory block and its benches.
- One natural sub-module, `ctrl_output_decode`: combinational state+opc -> control word. The FSM keeps the sequencing.

Test Plan:
- Reset held 3 cycles then released, RESET_CYCLES = 1 -> PCReset/SPReset/PCWrite/SPWrite = 1 during reset and one cycle after; InstWrite = 1 on the next cycle.
- inst = 0x4003 (LW) -> state path FETCH, DECODE, MADDR, MRD, WB with MemDst = 1 in MADDR/MRD; RegWrite = 1 exactly on cycle 5; next FETCH on cycle 6.
- inst = 0x6000 (PUSH), then 0x7000 (POP) -> SPWrite with SPSrc = 2 before MemWrite with MemDst = 3; POP gives SPSrc = 1 in MRD; totals 4 and 5 cycles.
- inst = 0x9005 with cmp_eq = 0, then 1 -> jcmp = 1, PCSrc = 3 both times; PCWrite = 0 then 1.
- enable = 0 for 4 cycles mid-LW (in MRD) -> state frozen, all strobes 0; on resume RegWrite fires once.
- inst = 0xC000 -> with CTRL_ILLEGAL_TRAP_EN, trap = 1 sticky until reset; without it, back to FETCH after 2 cycles. inst = 0xF000 -> halted = 1 until reset.
